bs_tap_sched: RTL and testbench
===============================

BS_TAP_SCHED -- requirements
Module: bs_tap_sched

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: start  input  1  sweep request; sampled only in IDLE.
REQ-004 SHALL provide: mu_shift  input  3  step-size shift code, latched on accepted start.
REQ-005 SHALL provide: x_in  input  1  shifter fill/direction bit, latched on accepted start.
REQ-006 SHALL provide: hold  input  1  stall request; freezes tap issue in ISSUE.
REQ-007 SHALL provide: s0, s1, s2, x  output  1 each  barrel-shifter control; equal to latched mu_shift[0], mu_shift[1], mu_shift[2] and x_in.
REQ-008 SHALL provide: tap_idx  output  5  weight tap being issued, range 2..16.
REQ-009 SHALL provide: issue_vld  output  1  tap_idx is valid this cycle.
REQ-010 SHALL provide: wr_en  output  1  write strobe for the shifted weight, 1 cycle after issue.
REQ-011 SHALL provide: wr_idx  output  5  tap index for wr_en.
REQ-012 SHALL provide: busy  output  1  high in ISSUE, DRAIN, DONE.
REQ-013 SHALL provide: done  output  1  one-cycle sweep-complete pulse.
REQ-014 SHALL provide: sweep_cnt  output  8  completed-sweep counter.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; no other reachable state.
REQ-016 IDLE: start=1 at clock edge SHALL latch mu_shift/x_in, set tap_idx=2, enter ISSUE.
REQ-017 start while busy=1 (ISSUE, DRAIN, DONE) SHALL be ignored; no effect on latched controls or sequence.
REQ-018 ISSUE with hold=0: issue_vld SHALL be 1; tap_idx SHALL increment by 1 each cycle.
REQ-019 ISSUE with hold=1: issue_vld SHALL be 0; tap_idx SHALL keep its value; state SHALL remain ISSUE.
REQ-020 ISSUE, tap_idx=16, hold=0: next state SHALL be DRAIN; tap_idx SHALL not advance past 16.
REQ-021 wr_en SHALL be issue_vld delayed one cycle; wr_idx SHALL be tap_idx delayed one cycle.
REQ-022 DRAIN SHALL last exactly one cycle, then DONE; hold SHALL be ignored in DRAIN and DONE.
REQ-023 DONE SHALL last one cycle with done=1, increment sweep_cnt by 1 (modulo 256, 255->0), then return to IDLE.
REQ-024 Unstalled sweep latency: start sampled at edge 0 -> issue_vld cycles 1..15, wr_en cycles 2..16, done at cycle 17, IDLE at cycle 18.
REQ-025 Each sweep SHALL produce exactly 15 wr_en pulses with wr_idx 2,3,...,16 in order, no duplicates, regardless of hold pattern.
REQ-026 s0, s1, s2, x SHALL stay constant from accepted start until the next accepted start; they keep values in IDLE.
REQ-027 issue_vld, wr_en, done SHALL be 0 in IDLE.

Reset
REQ-028 rst=1 SHALL immediately, without clock, force state IDLE, tap_idx=2, wr_idx=0, issue_vld=0, wr_en=0, busy=0, done=0, s0=s1=s2=x=0, sweep_cnt=0.
REQ-029 rst asserted mid-sweep SHALL abort the sweep: no done pulse, no sweep_cnt increment, no further wr_en.
REQ-030 After rst deasserts, first accepted start SHALL produce a full sweep per REQ-024.

Verification
REQ-031 Basic sweep: mu_shift=3'b101, x_in=1, start pulse, hold=0 -> s2,s1,s0,x=1,0,1,1; wr_idx 2..16 on cycles 2..16; done=1 at cycle 17; sweep_cnt=1.
REQ-032 Stall: hold=1 cycles 4-6 during sweep -> tap_idx frozen at value from cycle 4 (5) for 3 cycles; issue_vld=0 those cycles; done at cycle 20; still 15 wr_en pulses.
REQ-033 Busy start: start=1 every cycle with mu_shift changing -> only first start accepted; controls unchanged; done once at cycle 17; next sweep begins at cycle 18 edge.
REQ-034 Reset mid-sweep: rst=1 at cycle 8 -> all outputs to reset values at once; no done; sweep_cnt=0.
REQ-035 Counter wrap: 256 back-to-back sweeps -> sweep_cnt 255 then 0; hold during DRAIN/DONE has no effect.

Source files
------------

// File: rtl/bs_tap_sched_if.sv
// Control/status bundle for the barrel-shifter tap scheduler.
// The slave side is the scheduler; the master side drives sweeps and observes taps.
interface bs_tap_sched_if;
  logic       start;
  logic [2:0] mu_shift;
  logic       x_in;
  logic       hold;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       x;
  logic [4:0] tap_idx;
  logic       issue_vld;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic       busy;
  logic       done;
  logic [7:0] sweep_cnt;

  modport slave (
    input  start, mu_shift, x_in, hold,
    output s0, s1, s2, x, tap_idx, issue_vld, wr_en, wr_idx, busy, done, sweep_cnt
  );

  modport master (
    output start, mu_shift, x_in, hold,
    input  s0, s1, s2, x, tap_idx, issue_vld, wr_en, wr_idx, busy, done, sweep_cnt
  );
endinterface

// File: rtl/bs_tap_sched.sv
// Sweeps weight taps 2..16 through the barrel shifter, with a one-cycle
// write-back strobe trailing each issued tap and a completed-sweep counter.
module bs_tap_sched (
  input  logic                clk,
  input  logic                rst,
  bs_tap_sched_if.slave       bus
);

  localparam logic [4:0] TAP_FIRST = 5'd2;
  localparam logic [4:0] TAP_LAST  = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] tap_p0;
  logic       vld_p0;
  logic       vld_p1;
  logic [4:0] wr_idx_p1;
  logic [2:0] mu_q;
  logic       x_q;
  logic [7:0] cnt_q;
  logic       busy_c;
  logic       done_c;
  logic       accept;

  // Tap advance saturates at the last tap so the index never leaves 2..16.
  function automatic logic [4:0] tap_adv(input logic [4:0] t);
    if (t >= TAP_LAST) return TAP_LAST;
    return t + 5'd1;
  endfunction

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    vld_p0  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = ISSUE;
      end
      ISSUE: begin
        busy_c = 1'b1;
        if (!bus.hold) begin
          vld_p0 = 1'b1;
          if (tap_p0 == TAP_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_c  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // p0: tap issue and shifter controls latched at sweep start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_p0 <= TAP_FIRST;
      mu_q   <= 3'd0;
      x_q    <= 1'b0;
    end else if (accept) begin
      tap_p0 <= TAP_FIRST;
      mu_q   <= bus.mu_shift;
      x_q    <= bus.x_in;
    end else if (vld_p0) begin
      tap_p0 <= tap_adv(tap_p0);
    end
  end

  // p1: write-back strobe one cycle behind issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      wr_idx_p1 <= 5'd0;
    end else begin
      vld_p1    <= vld_p0;
      wr_idx_p1 <= tap_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= 8'd0;
    else if (state_q == DONE)   cnt_q <= cnt_q + 8'd1;
  end

  assign bus.s0        = mu_q[0];
  assign bus.s1        = mu_q[1];
  assign bus.s2        = mu_q[2];
  assign bus.x         = x_q;
  assign bus.tap_idx   = tap_p0;
  assign bus.issue_vld = vld_p0;
  assign bus.wr_en     = vld_p1;
  assign bus.wr_idx    = wr_idx_p1;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.sweep_cnt = cnt_q;

endmodule

// File: tb/tb_bs_tap_sched.sv
// Directed bench for bs_tap_sched: basic sweep, stall, busy start, async
// reset mid-sweep and sweep-counter wrap.
module tb_bs_tap_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [2:0] last_mu;
  logic       last_x;

  bs_tap_sched_if bus();

  bs_tap_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tap"},   32'(bus.tap_idx),   32'd2);
    check({tag, "_wridx"}, 32'(bus.wr_idx),    32'd0);
    check({tag, "_ivld"},  32'(bus.issue_vld), 32'd0);
    check({tag, "_wren"},  32'(bus.wr_en),     32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_done"},  32'(bus.done),      32'd0);
    check({tag, "_ctrl"},  32'({bus.s2, bus.s1, bus.s0, bus.x}), 32'd0);
    check({tag, "_cnt"},   32'(bus.sweep_cnt), 32'd0);
  endtask

  // Start a sweep at edge 0, then observe cycles 1..exp_done+1.
  task automatic run_sweep(input logic [2:0] mu, input logic xv, input int h_lo,
                           input int h_hi, input int exp_done, input bit busy_start,
                           input bit verbose);
    int  exp_wr;
    int  n_wr;
    int  n_done;
    int  done_cyc;
    int  nstall;
    bit  stalled;
    bus.start    = 1'b1;
    bus.mu_shift = mu;
    bus.x_in     = xv;
    bus.hold     = 1'b0;
    tick();
    exp_wr = 2; n_wr = 0; n_done = 0; done_cyc = 0; nstall = 0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      if (busy_start) begin
        bus.start    = 1'b1;
        bus.mu_shift = ~mu ^ 3'(c % 7);
        bus.x_in     = ~xv;
        last_mu      = bus.mu_shift;
        last_x       = bus.x_in;
      end else begin
        bus.start = 1'b0;
      end
      stalled  = (c >= h_lo) && (c <= h_hi);
      bus.hold = stalled;
      #1;
      if (bus.wr_en) begin
        if (verbose) check("wr_idx", 32'(bus.wr_idx), 32'(exp_wr));
        exp_wr++;
        n_wr++;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = c;
      end
      if (verbose) begin
        check("ctrl", 32'({bus.s2, bus.s1, bus.s0, bus.x}), 32'({mu, xv}));
        if (c <= exp_done - 2) begin
          check("issue_vld", 32'(bus.issue_vld), 32'(!stalled));
          check("tap_idx", 32'(bus.tap_idx), 32'(c + 1 - nstall));
          if (stalled) nstall++;
        end
        if (c == exp_done + 1) begin
          check("idle_busy", 32'(bus.busy), 32'd0);
          check("idle_outs", 32'({bus.issue_vld, bus.wr_en, bus.done}), 32'd0);
        end
      end
      @(posedge clk);
      #1;
    end
    check("n_wr", 32'(n_wr), 32'd15);
    check("n_done", 32'(n_done), 32'd1);
    check("done_cyc", 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    int any_wr;
    int any_done;
    bus.start = 1'b0; bus.mu_shift = 3'd0; bus.x_in = 1'b0; bus.hold = 1'b0;
    last_mu = 3'd0; last_x = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("por");
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // basic sweep
    run_sweep(3'b101, 1'b1, 0, -1, 17, 1'b0, 1'b1);
    check("basic_ctrl", 32'({bus.s2, bus.s1, bus.s0, bus.x}), 32'b1011);
    check("basic_cnt", 32'(bus.sweep_cnt), 32'd1);

    // stall for cycles 4..6
    run_sweep(3'b010, 1'b0, 4, 6, 20, 1'b0, 1'b1);
    check("stall_cnt", 32'(bus.sweep_cnt), 32'd2);

    // start held high with changing controls while busy
    run_sweep(3'b110, 1'b1, 0, -1, 17, 1'b1, 1'b1);
    bus.start = 1'b0;
    #1;
    check("busy_cnt", 32'(bus.sweep_cnt), 32'd3);
    check("next_busy", 32'(bus.busy), 32'd1);
    check("next_tap", 32'(bus.tap_idx), 32'd2);
    check("next_ctrl", 32'({bus.s2, bus.s1, bus.s0, bus.x}), 32'({last_mu, last_x}));

    // reset mid-sweep at cycle 8
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tick();
    bus.start = 1'b1; bus.mu_shift = 3'b111; bus.x_in = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    any_wr = 0; any_done = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.wr_en) any_wr++;
      if (bus.done) any_done++;
      tick();
    end
    check("abort_wr", 32'(any_wr), 32'd0);
    check("abort_done", 32'(any_done), 32'd0);
    check("abort_cnt", 32'(bus.sweep_cnt), 32'd0);
    run_sweep(3'b011, 1'b0, 0, -1, 17, 1'b0, 1'b1);
    check("post_rst_cnt", 32'(bus.sweep_cnt), 32'd1);

    // counter wrap with hold asserted through DRAIN and DONE
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tick();
    for (int k = 1; k <= 256; k++) begin
      run_sweep(3'(k), 1'(k), 16, 17, 17, 1'b0, 1'b0);
      if (k == 1)   check("wrap_cnt1", 32'(bus.sweep_cnt), 32'd1);
      if (k == 255) check("wrap_cnt255", 32'(bus.sweep_cnt), 32'd255);
      if (k == 256) check("wrap_cnt0", 32'(bus.sweep_cnt), 32'd0);
    end
    bus.hold = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
